jpeg_mcu_stream_merge: RTL

//  Multi-channel successor to the single-Y encoder top: merges the Huffman code streams of up to

---
 rtl/jpeg_mcu_stream_merge_pkg.sv | 29 ++
 rtl/jpeg_mcu_stream_merge_if.sv | 29 ++
 rtl/jpeg_mcu_stream_merge_fifo.sv | 46 ++++
 rtl/jpeg_mcu_stream_merge.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/jpeg_mcu_stream_merge_pkg.sv
// Shared encoder definitions: component modes, channel ids and MCU block layout.
package jpeg_enc_pkg;

    typedef enum logic [1:0] {
        MODE_444  = 2'd0,
        MODE_420  = 2'd1,
        MODE_GREY = 2'd2,
        MODE_RSVD = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        CH_Y  = 2'd0,
        CH_CB = 2'd1,
        CH_CR = 2'd2
    } ch_e;

    // 8x8 blocks a channel contributes to one MCU.
    function automatic logic [2:0] blocks_per_mcu(input logic [1:0] ch, input mode_e mode);
        return (ch == CH_Y && mode == MODE_420) ? 3'd4 : 3'd1;
    endfunction

    // Final channel visited in an MCU; grey and single-channel builds only visit Y.
    function automatic logic [1:0] last_channel(input mode_e mode, input int unsigned num_ch);
        if (mode == MODE_GREY || num_ch <= 1)
            return CH_Y;
        return 2'(num_ch - 1);
    endfunction

endpackage

// File: rtl/jpeg_mcu_stream_merge_if.sv
// Per-channel code input streams and merged code output stream.
interface jpeg_mcu_stream_merge_if #(
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned CODE_W = 16,
    parameter int unsigned LEN_W  = 8
);
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH*CODE_W-1:0] in_code;
    logic [NUM_CH*LEN_W-1:0]  in_len;
    logic [NUM_CH-1:0]        in_eob;
    logic [NUM_CH-1:0]        in_ready;
    logic                     out_valid;
    logic                     out_ready;
    logic [CODE_W-1:0]        out_code;
    logic [LEN_W-1:0]         out_len;
    logic [1:0]               out_ch;
    logic                     out_eob;
    logic                     out_mcu_end;

    modport slave (
        input  in_valid, in_code, in_len, in_eob, out_ready,
        output in_ready, out_valid, out_code, out_len, out_ch, out_eob, out_mcu_end
    );

    modport master (
        output in_valid, in_code, in_len, in_eob, out_ready,
        input  in_ready, out_valid, out_code, out_len, out_ch, out_eob, out_mcu_end
    );
endinterface

// File: rtl/jpeg_mcu_stream_merge_fifo.sv
// Synchronous code FIFO with wrap-bit pointers; head is a registered-array read.
module jpeg_code_fifo #(
    parameter int unsigned WIDTH = 25,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];
    assign w_push  = i_wr_en && !o_full;
    assign w_pop   = i_rd_en && !o_empty;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (w_push)
            r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end
endmodule

// File: rtl/jpeg_mcu_stream_merge.sv
// Merges per-component Huffman code streams into one stream in JPEG MCU order.
module jpeg_mcu_stream_merge
    import jpeg_enc_pkg::*;
#(
    parameter int unsigned NUM_CH     = 3,
    parameter int unsigned CODE_W     = 16,
    parameter int unsigned LEN_W      = 8,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [1:0]           mode,
    input  logic [15:0]          mcu_total,
    jpeg_mcu_stream_merge_if.slave bus,
    output logic                 busy,
    output logic                 done,
    output logic [NUM_CH-1:0]    overflow
);
    localparam int unsigned FW = 1 + LEN_W + CODE_W;

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_DONE} state_e;

    state_e            r_state, w_state_nx;
    mode_e             r_mode, w_mode_nx;
    logic [15:0]       r_total, w_total_nx;
    logic [15:0]       r_mcu, w_mcu_nx;
    logic [1:0]        r_ch, w_ch_nx;
    logic [2:0]        r_blk, w_blk_nx;
    logic [NUM_CH-1:0] r_overflow, w_overflow_nx;

    logic [NUM_CH-1:0] w_full, w_empty, w_pop;
    logic [FW-1:0]     w_head [NUM_CH];
    logic [FW-1:0]     w_sel_head;
    logic              w_sel_empty;
    logic              w_valid, w_fire, w_eob, w_last_blk, w_last_ch, w_ovf_clr;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_fifo
        jpeg_code_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clock     (clock),
            .reset_n   (reset_n),
            .i_wr_en   (bus.in_valid[g]),
            .i_wr_data ({bus.in_eob[g], bus.in_len[g*LEN_W +: LEN_W], bus.in_code[g*CODE_W +: CODE_W]}),
            .i_rd_en   (w_pop[g]),
            .o_full    (w_full[g]),
            .o_empty   (w_empty[g]),
            .o_head    (w_head[g])
        );
    end

    assign bus.in_ready = ~w_full;

    always_comb begin
        w_sel_head  = '0;
        w_sel_empty = 1'b1;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (r_ch == 2'(c)) begin
                w_sel_head  = w_head[c];
                w_sel_empty = w_empty[c];
            end
        end
    end

    assign w_valid    = (r_state == S_DRAIN) && !w_sel_empty;
    assign w_fire     = w_valid && bus.out_ready;
    assign w_eob      = w_sel_head[FW-1];
    assign w_last_blk = (r_blk + 3'd1) == blocks_per_mcu(r_ch, r_mode);
    assign w_last_ch  = (r_ch == last_channel(r_mode, NUM_CH));

    always_comb begin
        w_pop = '0;
        for (int unsigned c = 0; c < NUM_CH; c++)
            w_pop[c] = w_fire && (r_ch == 2'(c));
    end

    // Non-valid beats drive zeros so the output bus is clean outside DRAIN.
    assign bus.out_valid   = w_valid;
    assign bus.out_code    = w_valid ? w_sel_head[CODE_W-1:0] : '0;
    assign bus.out_len     = w_valid ? w_sel_head[CODE_W +: LEN_W] : '0;
    assign bus.out_eob     = w_valid && w_eob;
    assign bus.out_ch      = w_valid ? r_ch : '0;
    assign bus.out_mcu_end = w_valid && w_eob && w_last_blk && w_last_ch;
    assign busy            = (r_state != S_IDLE);
    assign done            = (r_state == S_DONE);
    assign overflow        = r_overflow;

    always_comb begin
        w_state_nx = r_state;
        w_mode_nx  = r_mode;
        w_total_nx = r_total;
        w_mcu_nx   = r_mcu;
        w_ch_nx    = r_ch;
        w_blk_nx   = r_blk;
        w_ovf_clr  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_mode_nx  = (mode_e'(mode) == MODE_RSVD) ? MODE_GREY : mode_e'(mode);
                    w_total_nx = mcu_total;
                    w_mcu_nx   = '0;
                    w_ch_nx    = '0;
                    w_blk_nx   = '0;
                    w_ovf_clr  = 1'b1;
                    w_state_nx = (mcu_total == 16'd0) ? S_DONE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_fire && w_eob) begin
                    if (w_last_blk) begin
                        w_blk_nx = '0;
                        if (w_last_ch) begin
                            w_ch_nx  = '0;
                            w_mcu_nx = r_mcu + 16'd1;
                            if (r_mcu + 16'd1 == r_total)
                                w_state_nx = S_DONE;
                        end else begin
                            w_ch_nx = r_ch + 2'd1;
                        end
                    end else begin
                        w_blk_nx = r_blk + 3'd1;
                    end
                end
            end
            S_DONE:  w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
        w_overflow_nx = (w_ovf_clr ? '0 : r_overflow) | (bus.in_valid & w_full);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_mode     <= MODE_444;
            r_total    <= '0;
            r_mcu      <= '0;
            r_ch       <= '0;
            r_blk      <= '0;
            r_overflow <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_mode     <= w_mode_nx;
            r_total    <= w_total_nx;
            r_mcu      <= w_mcu_nx;
            r_ch       <= w_ch_nx;
            r_blk      <= w_blk_nx;
            r_overflow <= w_overflow_nx;
        end
    end
endmodule
